// File: rtl/zoom_line_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : zoom_line_buf_ctrl
// Brief    : Line-RAM sequencer for the HDMI zoom path. Writes one source line,
//            then reads it back through a fixed-point DDA horizontal resampler.
// Revision : 1.0 - initial release
// ============================================================================
module zoom_line_buf_ctrl #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 24,
    parameter int FRAC_WIDTH = 12,
    parameter int RD_LATENCY = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             line_start,
    input  logic [ADDR_WIDTH:0]              cfg_src_width,
    input  logic [ADDR_WIDTH:0]              cfg_dst_width,
    input  logic [ADDR_WIDTH+FRAC_WIDTH-1:0] cfg_step,
    input  logic                             s_valid,
    input  logic [DATA_WIDTH-1:0]            s_data,
    output logic                             s_ready,
    output logic                             m_valid,
    output logic [DATA_WIDTH-1:0]            m_data,
    output logic                             busy,
    output logic                             line_done,
    output logic [ADDR_WIDTH-1:0]            ram_addr,
    output logic [DATA_WIDTH-1:0]            ram_wr_data,
    output logic                             ram_wr_en,
    input  logic [DATA_WIDTH-1:0]            ram_rd_data
);

    localparam int c_CNT_W = ADDR_WIDTH + 1;
    localparam int c_ACC_W = ADDR_WIDTH + FRAC_WIDTH + 1;
    localparam logic [c_CNT_W-1:0] c_MAX_WIDTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [c_CNT_W-1:0] c_ONE       = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                           r_state;
    state_t                           w_next;

    logic [c_CNT_W-1:0]               r_src_w;
    logic [c_CNT_W-1:0]               r_dst_w;
    logic [ADDR_WIDTH+FRAC_WIDTH-1:0] r_step;
    logic [c_CNT_W-1:0]               r_wr_cnt;
    logic [c_CNT_W-1:0]               r_rd_cnt;
    logic [c_ACC_W-1:0]               r_acc;
    logic [RD_LATENCY:0]              r_vld;
    logic                             r_busy;
    logic [ADDR_WIDTH-1:0]            r_ram_addr;
    logic [DATA_WIDTH-1:0]            r_ram_wr_data;
    logic                             r_ram_wr_en;

    logic                             w_start;
    logic [c_CNT_W-1:0]               w_src_sat;
    logic [c_CNT_W-1:0]               w_dst_sat;
    logic [c_CNT_W-1:0]               w_src_last;
    logic                             w_wr_fire;
    logic                             w_wr_last;
    logic                             w_rd_issue;
    logic                             w_rd_last;
    logic                             w_pipe_empty;
    logic [c_CNT_W-1:0]               w_acc_int;
    logic [ADDR_WIDTH-1:0]            w_rd_addr;
    logic [c_ACC_W:0]                 w_acc_sum;
    logic [c_ACC_W-1:0]               w_acc_next;
    logic                             w_s_ready;
    logic                             w_line_done;

    // A new line is only taken once busy has fully fallen after the previous one.
    assign w_start    = (r_state == S_IDLE) && line_start && !r_busy;
    assign w_src_sat  = (cfg_src_width > c_MAX_WIDTH) ? c_MAX_WIDTH : cfg_src_width;
    assign w_dst_sat  = (cfg_dst_width > c_MAX_WIDTH) ? c_MAX_WIDTH : cfg_dst_width;
    assign w_src_last = r_src_w - c_ONE;

    assign w_wr_fire  = (r_state == S_WRITE) && s_valid;
    assign w_wr_last  = w_wr_fire && (r_wr_cnt == w_src_last);
    assign w_rd_issue = (r_state == S_READ);
    assign w_rd_last  = w_rd_issue && (r_rd_cnt == (r_dst_w - c_ONE));

    // Only the output stage may still be set once the last read is on its way out.
    assign w_pipe_empty = (r_vld[RD_LATENCY-1:0] == '0);

    // Integer part of the DDA position, clamped to the last source pixel.
    assign w_acc_int  = r_acc[c_ACC_W-1:FRAC_WIDTH];
    assign w_rd_addr  = (w_acc_int > w_src_last) ? w_src_last[ADDR_WIDTH-1:0]
                                                 : w_acc_int[ADDR_WIDTH-1:0];

    // Saturating accumulate keeps the position monotonic for any step value.
    assign w_acc_sum  = {1'b0, r_acc} + {2'b00, r_step};
    assign w_acc_next = w_acc_sum[c_ACC_W] ? {c_ACC_W{1'b1}} : w_acc_sum[c_ACC_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_s_ready   = 1'b0;
        w_line_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if ((w_src_sat == '0) || (w_dst_sat == '0)) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                w_s_ready = 1'b1;
                if (w_wr_last) begin
                    w_next = S_READ;
                end
            end
            S_READ: begin
                if (w_rd_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pipe_empty) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_line_done = 1'b1;
                w_next      = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src_w       <= '0;
            r_dst_w       <= '0;
            r_step        <= '0;
            r_wr_cnt      <= '0;
            r_rd_cnt      <= '0;
            r_acc         <= '0;
            r_vld         <= '0;
            r_busy        <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_wr_data <= '0;
            r_ram_wr_en   <= 1'b0;
        end else begin
            r_ram_wr_en <= 1'b0;
            // Bit 0 marks the cycle an address is presented to the RAM.
            r_vld       <= {r_vld[RD_LATENCY-1:0], w_rd_issue};
            r_busy      <= (w_next != S_IDLE) || (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_src_w  <= w_src_sat;
                        r_dst_w  <= w_dst_sat;
                        r_step   <= cfg_step;
                        r_wr_cnt <= '0;
                        r_rd_cnt <= '0;
                        r_acc    <= '0;
                    end
                end
                S_WRITE: begin
                    if (w_wr_fire) begin
                        r_ram_addr    <= r_wr_cnt[ADDR_WIDTH-1:0];
                        r_ram_wr_data <= s_data;
                        r_ram_wr_en   <= 1'b1;
                        r_wr_cnt      <= r_wr_cnt + c_ONE;
                        if (w_wr_last) begin
                            r_acc    <= '0;
                            r_rd_cnt <= '0;
                        end
                    end
                end
                S_READ: begin
                    r_ram_addr <= w_rd_addr;
                    r_acc      <= w_acc_next;
                    r_rd_cnt   <= r_rd_cnt + c_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    assign s_ready     = w_s_ready;
    assign line_done   = w_line_done;
    assign busy        = r_busy;
    assign m_valid     = r_vld[RD_LATENCY];
    assign m_data      = ram_rd_data;
    assign ram_addr    = r_ram_addr;
    assign ram_wr_data = r_ram_wr_data;
    assign ram_wr_en   = r_ram_wr_en;

endmodule
`default_nettype wire
